// File: rtl/game_grid_overlay_pkg.sv
// Shared screen, colour and bus definitions for the game-grid overlay.
`default_nettype none

package game_pkg;

  localparam int SCREEN_W  = 1024;
  localparam int SCREEN_H  = 768;
  localparam int MAX_BOARD = 4;

  localparam logic [11:0] THIN_COLOR   = 12'h777;
  localparam logic [11:0] THICK_COLOR  = 12'hFFF;
  localparam logic [11:0] CURSOR_COLOR = 12'hF00;

  // CW indexes a cell; NW must also hold N itself (the closing border index).
  localparam int CW = $clog2(MAX_BOARD * MAX_BOARD);
  localparam int NW = $clog2(MAX_BOARD * MAX_BOARD + 1);

  typedef logic [CW-1:0] cell_idx_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

`default_nettype wire

// File: rtl/game_grid_overlay_axis.sv
// One axis of the grid: pixel-in-cell, cell and block counters, line classification.
`default_nettype none

module grid_axis_counter
  import game_pkg::*;
#(
  parameter int CELL_PX  = 16,
  parameter int THICK_PX = 2,
  localparam int PW      = $clog2(CELL_PX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [NW-1:0] i_n,
  input  logic [2:0]    i_b,
  output logic [NW-1:0] o_cell,
  output logic          o_on_thick,
  output logic          o_on_thin,
  output logic          o_active
);

  logic [PW-1:0] r_px,   w_px;
  logic [NW-1:0] r_cell, w_cell;
  logic [2:0]    r_blk,  w_blk;
  logic          r_act,  w_act;
  logic          w_end;
  logic          w_thick;

  // Registers hold the previous position; w_* is the position of the current pixel.
  assign w_end = (r_cell == i_n) && (r_px == '0);

  always_comb begin
    w_px   = r_px;
    w_cell = r_cell;
    w_blk  = r_blk;
    w_act  = r_act;
    if (i_load) begin
      w_px   = '0;
      w_cell = '0;
      w_blk  = '0;
      w_act  = 1'b1;
    end else if (i_step && r_act) begin
      if (w_end) begin
        w_act = 1'b0;
      end else if (r_px == PW'(CELL_PX - 1)) begin
        w_px   = '0;
        w_cell = r_cell + 1'b1;
        w_blk  = (r_blk == i_b - 3'd1) ? 3'd0 : r_blk + 3'd1;
      end else begin
        w_px = r_px + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_px   <= '0;
      r_cell <= '0;
      r_blk  <= '0;
      r_act  <= 1'b0;
    end else begin
      r_px   <= w_px;
      r_cell <= w_cell;
      r_blk  <= w_blk;
      r_act  <= w_act;
    end
  end

  assign w_thick    = w_act && (w_blk == 3'd0) && (w_px < PW'(THICK_PX));
  assign o_on_thick = w_thick;
  assign o_on_thin  = w_act && (w_px == '0) && !w_thick;
  assign o_cell     = w_cell;
  assign o_active   = w_act;

endmodule

`default_nettype wire

// File: rtl/game_grid_overlay.sv
// Centred N x N game-grid overlay on a 1024x768 VGA stream, two-cycle pipeline.
`default_nettype none

module game_grid_overlay
  import game_pkg::*;
#(
  parameter int CELL_PX  = 16,
  parameter int THICK_PX = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      is_game_on,
  input  logic [2:0] board_size,
  input  logic      cursor_en,
  input  cell_idx_t cursor_x,
  input  cell_idx_t cursor_y,
  input  vga_bus_t  bus_in,
  output vga_bus_t  bus_out
);

  logic          r_vb_d, r_on, r_cen;
  logic [2:0]    r_b;
  cell_idx_t     r_cx, r_cy;
  logic [NW-1:0] r_n;
  logic [10:0]   r_x0, r_y0;
  logic          r_en;

  logic          w_latch;
  logic [2:0]    w_b_clamp;
  logic [NW-1:0] w_bn, w_n;
  logic [10:0]   w_w, w_x0, w_y0;

  assign w_latch   = bus_in.vblnk && !r_vb_d;
  assign w_b_clamp = (board_size > 3'(MAX_BOARD)) ? 3'(MAX_BOARD) : board_size;
  assign w_bn      = NW'(r_b);
  assign w_n       = w_bn * w_bn;
  assign w_w       = 11'(CELL_PX) * 11'(w_n);
  assign w_x0      = (11'(SCREEN_W) - w_w) >> 1;
  assign w_y0      = (11'(SCREEN_H) - w_w) >> 1;

  // Controls are sampled only at the vblank rising edge so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vb_d <= 1'b0;
      r_on   <= 1'b0;
      r_cen  <= 1'b0;
      r_b    <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_n    <= '0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_en   <= 1'b0;
    end else begin
      r_vb_d <= bus_in.vblnk;
      if (w_latch) begin
        r_on  <= is_game_on;
        r_cen <= cursor_en;
        r_b   <= w_b_clamp;
        r_cx  <= cursor_x;
        r_cy  <= cursor_y;
      end
      r_n  <= w_n;
      r_x0 <= w_x0;
      r_y0 <= w_y0;
      r_en <= r_on && (r_b != 3'd0);
    end
  end

  logic [NW-1:0] w_cell_x, w_cell_y;
  logic          w_x_thk, w_x_thn, w_x_act;
  logic          w_y_thk, w_y_thn, w_y_act;

  grid_axis_counter #(.CELL_PX(CELL_PX), .THICK_PX(THICK_PX)) u_x_axis (
    .clk        (clk),
    .rst        (rst),
    .i_load     (bus_in.hcount == r_x0),
    .i_step     (1'b1),
    .i_n        (r_n),
    .i_b        (r_b),
    .o_cell     (w_cell_x),
    .o_on_thick (w_x_thk),
    .o_on_thin  (w_x_thn),
    .o_active   (w_x_act)
  );

  grid_axis_counter #(.CELL_PX(CELL_PX), .THICK_PX(THICK_PX)) u_y_axis (
    .clk        (clk),
    .rst        (rst),
    .i_load     (bus_in.vcount == r_y0),
    .i_step     (bus_in.hcount == 11'd0),
    .i_n        (r_n),
    .i_b        (r_b),
    .o_cell     (w_cell_y),
    .o_on_thick (w_y_thk),
    .o_on_thin  (w_y_thn),
    .o_active   (w_y_act)
  );

  logic w_in, w_thick, w_thin, w_cursor;

  assign w_in     = r_en && w_x_act && w_y_act;
  assign w_thick  = w_in && (w_x_thk || w_y_thk);
  assign w_thin   = w_in && !w_thick && (w_x_thn || w_y_thn);
  assign w_cursor = w_in && r_cen && !(w_x_thk || w_x_thn || w_y_thk || w_y_thn)
                    && (w_cell_x == NW'(r_cx)) && (w_cell_y == NW'(r_cy))
                    && (NW'(r_cx) < r_n) && (NW'(r_cy) < r_n);

  vga_bus_t r_s1, r_out;
  logic     r_thk1, r_thn1, r_cur1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= '0;
      r_thk1 <= 1'b0;
      r_thn1 <= 1'b0;
      r_cur1 <= 1'b0;
      r_out  <= '0;
    end else begin
      r_s1   <= bus_in;
      r_thk1 <= w_thick;
      r_thn1 <= w_thin;
      r_cur1 <= w_cursor;
      r_out  <= r_s1;
      if (!(r_s1.hblnk || r_s1.vblnk)) begin
        if (r_thk1)      r_out.rgb <= THICK_COLOR;
        else if (r_thn1) r_out.rgb <= THIN_COLOR;
        else if (r_cur1) r_out.rgb <= CURSOR_COLOR;
      end
    end
  end

  assign bus_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_game_grid_overlay.sv
// Directed bench for game_grid_overlay: grid geometry, cursor, frame latching, reset, alignment.
`default_nettype none

module tb_game_grid_overlay;
  import game_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      is_game_on, cursor_en;
  logic [2:0] board_size;
  cell_idx_t cursor_x, cursor_y;
  vga_bus_t  bin, bout;

  int n_chk = 0;
  int n_err = 0;
  int mis_full = 0, mis_align = 0, mis_blank = 0;
  logic rnd = 1'b0;
  logic [11:0] pix [int];
  vga_bus_t h1, h2;

  always #5 clk = ~clk;

  game_grid_overlay #(.CELL_PX(16), .THICK_PX(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .is_game_on (is_game_on),
    .board_size (board_size),
    .cursor_en  (cursor_en),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .bus_in     (bin),
    .bus_out    (bout)
  );

  // Reference: outputs equal inputs seen two negedges earlier, rgb aside.
  always @(negedge clk) begin
    if (rst) begin
      if (bout !== h2) mis_full++;
      if (bout[39:12] !== h2[39:12]) mis_align++;
      if ((h2.hblnk || h2.vblnk) && (bout.rgb !== h2.rgb)) mis_blank++;
      pix[int'(bout.vcount) * 2048 + int'(bout.hcount)] = bout.rgb;
    end
    h2 = h1;
    h1 = bin;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] px_at(input int v, input int h);
    if (pix.exists(v * 2048 + h)) return pix[v * 2048 + h];
    return 12'hxxx;
  endfunction

  function automatic logic [11:0] col();
    return rnd ? 12'($urandom) : 12'h0A5;
  endfunction

  task automatic cyc(input int v, input int h, input logic hb, input logic vb, input logic [11:0] c);
    bin.hcount = 11'(h);
    bin.vcount = 11'(v);
    bin.hsync  = hb;
    bin.hblnk  = hb;
    bin.vsync  = vb;
    bin.vblnk  = vb;
    bin.rgb    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int v, input int hs, input int he);
    cyc(v, 0, 1'b0, 1'b0, col());
    for (int h = hs; h <= he; h++) cyc(v, h, 1'b0, 1'b0, col());
  endtask

  task automatic rows(input int a, input int b);
    for (int v = a; v <= b; v++) line(v, 1, 0);
  endtask

  task automatic frame();
    cyc(770, 5, 1'b1, 1'b0, col());
    for (int i = 0; i < 5; i++) cyc(770, 6 + i, 1'b1, 1'b1, col());
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) cyc(799, 1100 + i, 1'b1, 1'b0, col());
  endtask

  int base_a, base_b, cnt;

  initial begin
    rst = 1'b0;
    is_game_on = 1'b0; cursor_en = 1'b0; board_size = 3'd0;
    cursor_x = '0; cursor_y = '0;
    bin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 64'(bout), 64'd0);
    rst = 1'b1;

    // B=3: X0=440, Y0=312, W=144
    is_game_on = 1'b1; board_size = 3'd3;
    frame();
    rows(312, 312);
    line(313, 430, 600);
    rows(314, 319);
    line(320, 430, 600);
    flush();
    chk("b3_y_thick_313_460", 64'(px_at(313, 460)), 64'hFFF);
    chk("b3_thick_440", 64'(px_at(320, 440)), 64'hFFF);
    chk("b3_thick_441", 64'(px_at(320, 441)), 64'hFFF);
    chk("b3_thick_488", 64'(px_at(320, 488)), 64'hFFF);
    chk("b3_thick_536", 64'(px_at(320, 536)), 64'hFFF);
    chk("b3_thick_584", 64'(px_at(320, 584)), 64'hFFF);
    chk("b3_thin_456", 64'(px_at(320, 456)), 64'h777);
    chk("b3_bg_460", 64'(px_at(320, 460)), 64'h0A5);
    chk("b3_out_439", 64'(px_at(320, 439)), 64'h0A5);
    chk("b3_out_585", 64'(px_at(320, 585)), 64'h0A5);

    // B=2 with cursor (1,2): X0=480, Y0=352
    board_size = 3'd2; cursor_en = 1'b1; cursor_x = 4'd1; cursor_y = 4'd2;
    frame();
    rows(352, 374);
    line(375, 470, 520);
    rows(376, 389);
    line(390, 470, 520);
    flush();
    chk("cur_fill_500_390", 64'(px_at(390, 500)), 64'hF00);
    chk("cur_thin_496_390", 64'(px_at(390, 496)), 64'h777);
    chk("cur_thick_512_390", 64'(px_at(390, 512)), 64'hFFF);
    chk("cur_other_row_375", 64'(px_at(375, 500)), 64'h0A5);

    // Cursor column equal to N is hidden
    cursor_x = 4'd4; cursor_y = 4'd0;
    frame();
    rows(352, 359);
    line(360, 470, 550);
    flush();
    cnt = 0;
    for (int h = 470; h <= 550; h++) if (px_at(360, h) == 12'hF00) cnt++;
    chk("cur_hidden_count", 64'(cnt), 64'd0);
    chk("cur_hidden_500_360", 64'(px_at(360, 500)), 64'h0A5);
    chk("cur_hidden_thick_544", 64'(px_at(360, 544)), 64'hFFF);

    // Asynchronous reset at pixel (500,400), then pass-through until the next latch
    rows(361, 399);
    cyc(400, 0, 1'b0, 1'b0, col());
    for (int h = 470; h <= 499; h++) cyc(400, h, 1'b0, 1'b0, col());
    bin.hcount = 11'd500;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_async_zero", 64'(bout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    line(401, 470, 560);
    base_a = mis_full;
    line(402, 470, 560);
    line(403, 470, 560);
    flush();
    chk("rst_passthru", 64'(mis_full - base_a), 64'd0);
    chk("rst_no_grid_512_402", 64'(px_at(402, 512)), 64'h0A5);
    frame();
    rows(352, 359);
    line(360, 470, 550);
    flush();
    chk("rst_grid_back_512", 64'(px_at(360, 512)), 64'hFFF);

    // Mid-frame board_size change is ignored until the next vblank edge
    board_size = 3'd3; cursor_en = 1'b0;
    frame();
    rows(312, 400);
    board_size = 3'd2;
    line(401, 430, 520);
    flush();
    chk("mid_keep_b3_488", 64'(px_at(401, 488)), 64'hFFF);
    frame();
    rows(352, 359);
    line(360, 470, 550);
    flush();
    chk("next_b2_thick_512", 64'(px_at(360, 512)), 64'hFFF);
    chk("next_b2_bg_488", 64'(px_at(360, 488)), 64'h0A5);

    // board_size=7 clamps to 4: X0=384, Y0=256
    board_size = 3'd7;
    frame();
    rows(256, 259);
    line(260, 380, 410);
    flush();
    chk("b7_thick_384", 64'(px_at(260, 384)), 64'hFFF);
    chk("b7_thin_400", 64'(px_at(260, 400)), 64'h777);
    chk("b7_bg_388", 64'(px_at(260, 388)), 64'h0A5);
    chk("b7_out_383", 64'(px_at(260, 383)), 64'h0A5);

    // Disabled overlay: bit-exact two-cycle pass-through
    rnd = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      is_game_on = (pass == 1);
      board_size = (pass == 1) ? 3'd0 : 3'd3;
      frame();
      base_a = mis_full;
      for (int v = 300; v <= 470; v++) begin
        if (v % 10 == 0) line(v, 380, 650);
        else line(v, 1, 0);
      end
      flush();
      chk(pass == 0 ? "passthru_game_off" : "passthru_b0", 64'(mis_full - base_a), 64'd0);
    end

    // Random stream with the grid enabled: alignment and blanking
    is_game_on = 1'b1; board_size = 3'd3; cursor_en = 1'b1; cursor_x = 4'd2; cursor_y = 4'd3;
    frame();
    base_a = mis_align;
    base_b = mis_blank;
    for (int i = 0; i < 400; i++) begin
      bin.hcount = 11'($urandom_range(0, 1100));
      bin.vcount = 11'($urandom_range(0, 800));
      bin.hsync  = 1'($urandom);
      bin.hblnk  = 1'($urandom);
      bin.vsync  = 1'($urandom);
      bin.vblnk  = 1'($urandom);
      bin.rgb    = 12'($urandom);
      @(posedge clk);
      #1;
    end
    flush();
    chk("rand_align", 64'(mis_align - base_a), 64'd0);
    chk("rand_blank_rgb", 64'(mis_blank - base_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
